template_match_ctrl: RTL and testbench

//  Sequences the squared-euclidean-distance datapath to score one utterance feature vector against
//  NUM_WORDS stored word templates. Streams feature/template coefficient pairs into the datapath,

---
 rtl/template_match_ctrl.sv | 143 ++++++++++++++
 tb/tb_template_match_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/template_match_ctrl.sv
// template_match_ctrl: sequences a squared-distance datapath over NUM_WORDS templates
// and reports the minimum-distance word.
module template_match_ctrl #(
    parameter int NUM_WORDS = 10,
    parameter int VEC_LEN   = 64,
    parameter int ADDR_W    = 6,
    parameter int TADDR_W   = 10
) (
    input  logic               iclk,
    input  logic               irstn,
    input  logic               istart,
    input  logic               iabort,
    output logic [ADDR_W-1:0]  ofeat_addr,
    input  logic [15:0]        ifeat_data,
    output logic [TADDR_W-1:0] otmpl_addr,
    input  logic [15:0]        itmpl_data,
    output logic               oed_clr_n,
    output logic [15:0]        oed_data_0,
    output logic [15:0]        oed_data_1,
    output logic               oed_valid,
    output logic [3:0]         oed_word,
    input  logic               ied_valid,
    input  logic [3:0]         ied_word,
    input  logic [63:0]        ied_data,
    output logic               obusy,
    output logic               odone,
    output logic [3:0]         obest_word,
    output logic [63:0]        obest_dist,
    output logic               oerr
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, WAIT, COMPARE, DONE} state_t;

    state_t             state;
    logic [3:0]         word;
    logic [3:0]         best_word;
    logic [63:0]        best_dist;
    logic [63:0]        captured;
    logic [CNT_W-1:0]   beats;
    logic               wait_ph;
    logic               better;
    logic               last_k;
    logic               last_word;
    logic [TADDR_W-1:0] base;

    assign better     = captured < best_dist;
    assign last_k     = ofeat_addr == ADDR_W'(VEC_LEN - 1);
    assign last_word  = word == 4'(NUM_WORDS - 1);
    assign base       = TADDR_W'(word) * TADDR_W'(VEC_LEN);
    // read data is only meaningful on the cycle after an issue, so gate it by the valid
    assign oed_data_0 = oed_valid ? itmpl_data : 16'd0;
    assign oed_data_1 = oed_valid ? ifeat_data : 16'd0;

    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state      <= IDLE;
            word       <= 4'd0;
            best_word  <= 4'd0;
            best_dist  <= '1;
            captured   <= 64'd0;
            beats      <= '0;
            wait_ph    <= 1'b0;
            ofeat_addr <= '0;
            otmpl_addr <= '0;
            oed_clr_n  <= 1'b1;
            oed_valid  <= 1'b0;
            oed_word   <= 4'd0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
            obest_word <= 4'd0;
            obest_dist <= 64'd0;
            oerr       <= 1'b0;
        end else begin
            oed_valid <= state == STREAM;
            oed_clr_n <= 1'b1;
            odone     <= 1'b0;
            // the last beat of a word lands in the second WAIT cycle
            if ((state == STREAM || state == WAIT) && ied_valid) begin
                beats <= beats + 1'b1;
                if (ied_word != word) oerr <= 1'b1;
                if (beats == CNT_W'(VEC_LEN - 1)) captured <= ied_data;
            end
            if (iabort) begin
                state     <= IDLE;
                oed_valid <= 1'b0;
                obusy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (istart) begin
                        state     <= CLEAR;
                        word      <= 4'd0;
                        oed_word  <= 4'd0;
                        best_dist <= '1;
                        best_word <= 4'd0;
                        oerr      <= 1'b0;
                        obusy     <= 1'b1;
                        oed_clr_n <= 1'b0;
                    end
                    CLEAR: begin
                        state      <= STREAM;
                        beats      <= '0;
                        ofeat_addr <= '0;
                        otmpl_addr <= base;
                    end
                    STREAM: if (last_k) begin
                        state   <= WAIT;
                        wait_ph <= 1'b0;
                    end else begin
                        ofeat_addr <= ofeat_addr + 1'b1;
                        otmpl_addr <= otmpl_addr + 1'b1;
                    end
                    WAIT: begin
                        wait_ph <= 1'b1;
                        if (wait_ph) state <= COMPARE;
                    end
                    COMPARE: begin
                        if (better) begin
                            best_dist <= captured;
                            best_word <= word;
                        end
                        if (last_word) begin
                            state      <= DONE;
                            odone      <= 1'b1;
                            obest_dist <= better ? captured : best_dist;
                            obest_word <= better ? word : best_word;
                        end else begin
                            state     <= CLEAR;
                            word      <= word + 1'b1;
                            oed_word  <= word + 1'b1;
                            oed_clr_n <= 1'b0;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        obusy <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_template_match_ctrl.sv
// tb_template_match_ctrl: directed vectors against the controller with ROM,
// feature buffer and squared-distance datapath models.
module tb_template_match_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        force_word = 1'b0;
    logic [1:0]  feat_addr;
    logic [15:0] feat_data;
    logic [3:0]  tmpl_addr;
    logic [15:0] tmpl_data;
    logic        ed_clr_n;
    logic [15:0] ed_data_0;
    logic [15:0] ed_data_1;
    logic        ed_valid;
    logic [3:0]  ed_word;
    logic        dp_valid;
    logic [3:0]  dp_word;
    logic [63:0] dp_sum;
    logic [15:0] dif;
    logic        busy;
    logic        done;
    logic [3:0]  best_word;
    logic [63:0] best_dist;
    logic        err;
    logic [15:0] feat [4];
    logic [15:0] tmpl [12];
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic [15:0]            f;
        logic [2:0][3:0][15:0]  t;
        logic [3:0]             bw;
        logic [63:0]            bd;
    } vec_t;
    vec_t vecs [5];

    template_match_ctrl #(.NUM_WORDS(3), .VEC_LEN(4), .ADDR_W(2), .TADDR_W(4)) dut (
        .iclk(clk), .irstn(rst_n), .istart(start), .iabort(abort),
        .ofeat_addr(feat_addr), .ifeat_data(feat_data),
        .otmpl_addr(tmpl_addr), .itmpl_data(tmpl_data),
        .oed_clr_n(ed_clr_n), .oed_data_0(ed_data_0), .oed_data_1(ed_data_1),
        .oed_valid(ed_valid), .oed_word(ed_word),
        .ied_valid(dp_valid), .ied_word(force_word ? dp_word ^ 4'd1 : dp_word), .ied_data(dp_sum),
        .obusy(busy), .odone(done), .obest_word(best_word), .obest_dist(best_dist), .oerr(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        feat_data <= feat[feat_addr];
        tmpl_data <= tmpl[tmpl_addr];
    end

    assign dif = ed_data_0 > ed_data_1 ? ed_data_0 - ed_data_1 : ed_data_1 - ed_data_0;

    always @(posedge clk or negedge ed_clr_n) begin
        if (!ed_clr_n) begin
            dp_sum   <= 64'd0;
            dp_valid <= 1'b0;
            dp_word  <= 4'd0;
        end else begin
            dp_valid <= ed_valid;
            if (ed_valid) begin
                dp_sum  <= dp_sum + 64'(dif) * 64'(dif);
                dp_word <= ed_word;
            end
        end
    end

    function automatic logic [3:0][15:0] q(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 4; i++) feat[i] = v.f;
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) tmpl[w * 4 + k] = v.t[w][k];
    endtask

    // one operation: pulses start, then runs a fixed window injecting optional events
    task automatic go(input int again_at, input int abort_at, input int force_at,
                      output int first_done, output int ndone);
        first_done = 0;
        ndone = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = (c == again_at);
            abort = (c == abort_at);
            force_word = (c == force_at);
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
        end
    endtask

    task automatic chk_result(input string name, input vec_t v, input int fd, input int nd);
        chk({name, " done_cycle"}, 64'(fd), 64'd25);
        chk({name, " done_count"}, 64'(nd), 64'd1);
        chk({name, " best_word"}, 64'(best_word), 64'(v.bw));
        chk({name, " best_dist"}, best_dist, v.bd);
        chk({name, " busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int fd;
        int nd;
        vecs[0] = '{16'd10, {q(13, 13, 13, 13), q(10, 10, 10, 10), q(12, 12, 12, 12)}, 4'd1, 64'd0};
        vecs[1] = '{16'hFFFF, {q(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), q(0, 0, 0, 0), q(0, 0, 0, 0)}, 4'd2, 64'd0};
        vecs[2] = '{16'hFFFF, {q(0, 0, 0, 0), q(0, 0, 0, 0), q(0, 0, 0, 0)}, 4'd0, 64'h3_FFF8_0004};
        vecs[3] = '{16'd10, {q(8, 8, 8, 8), q(14, 12, 10, 10), q(12, 12, 12, 12)}, 4'd0, 64'd16};
        vecs[4] = '{16'd5, {q(5, 5, 5, 5), q(5, 5, 5, 5), q(6, 5, 5, 5)}, 4'd1, 64'd0};
        load(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst clr_n", 64'(ed_clr_n), 64'd1);
        chk("rst valid", 64'(ed_valid), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst best_dist", best_dist, 64'd0);
        chk("rst tmpl_addr", 64'(tmpl_addr), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            load(vecs[i]);
            go(0, 0, 0, fd, nd);
            chk_result($sformatf("vec%0d", i), vecs[i], fd, nd);
            chk($sformatf("vec%0d err", i), 64'(err), 64'd0);
        end

        load(vecs[0]);
        go(11, 0, 0, fd, nd);
        chk_result("start_in_stream", vecs[0], fd, nd);

        load(vecs[3]);
        go(0, 0, 0, fd, nd);
        chk_result("pre_abort", vecs[3], fd, nd);
        load(vecs[0]);
        go(0, 14, 0, fd, nd);
        chk("abort done_count", 64'(nd), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort valid", 64'(ed_valid), 64'd0);
        chk("abort clr_n", 64'(ed_clr_n), 64'd1);
        chk("abort best_word hold", 64'(best_word), 64'd0);
        chk("abort best_dist hold", best_dist, 64'd16);
        go(0, 0, 0, fd, nd);
        chk_result("after_abort", vecs[0], fd, nd);

        load(vecs[2]);
        go(0, 0, 12, fd, nd);
        chk_result("tag_fault", vecs[2], fd, nd);
        chk("tag_fault err", 64'(err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err sticky", 64'(err), 64'd1);
        load(vecs[0]);
        go(0, 0, 0, fd, nd);
        chk_result("err_clear_run", vecs[0], fd, nd);
        chk("err cleared", 64'(err), 64'd0);

        load(vecs[2]);
        go(0, 0, 12, fd, nd);
        load(vecs[0]);
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_rst busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst best_dist", best_dist, 64'd0);
        chk("midrst err", 64'(err), 64'd0);
        chk("midrst feat_addr", 64'(feat_addr), 64'd0);
        chk("midrst tmpl_addr", 64'(tmpl_addr), 64'd0);
        chk("midrst ed_word", 64'(ed_word), 64'd0);
        chk("midrst clr_n", 64'(ed_clr_n), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        go(0, 0, 0, fd, nd);
        chk_result("after_rst", vecs[0], fd, nd);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
